// File: rtl/multicycle_alu_if.sv
// Request/response channel bundle for multicycle_alu: operands and control in,
// registered result out, each side with its own valid/ready pair.
interface multicycle_alu_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            alu_control;
  logic [DATA_WIDTH-1:0] src_a;
  logic [DATA_WIDTH-1:0] src_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] result;
  logic                  zero;

  // Requester / consumer side (operand-mux stage and writeback).
  modport master (
    output in_valid, alu_control, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero
  );

  // ALU side.
  modport slave (
    input  in_valid, alu_control, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/multicycle_alu.sv
// Execute-stage ALU with valid/ready channels; single-cycle arith/logic/compare and
// bit-serial shifts, or single-cycle shifts when MULTICYCLE_ALU_BARREL_SHIFT_EN is defined.
module multicycle_alu #(
  parameter int DATA_WIDTH = 32
) (
  input logic             clk,
  input logic             rst_n,
  multicycle_alu_if.slave alu_bus
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_SLTU = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_SLL  = 3'b110;
  localparam logic [2:0] OP_SRL  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  zero_q, zero_d;
  logic [DATA_WIDTH-1:0] alu_result;
  logic [SHAMT_W-1:0]    shamt;
  logic                  is_shift;
  logic                  lt_signed;
  logic                  lt_unsigned;

`ifndef MULTICYCLE_ALU_BARREL_SHIFT_EN
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [SHAMT_W-1:0]    cnt_q, cnt_d;
  logic                  left_q, left_d;
  logic [DATA_WIDTH-1:0] acc_step;
`endif

  assign shamt       = alu_bus.src_b[SHAMT_W-1:0];
  assign is_shift    = (alu_bus.alu_control[2:1] == 2'b11);
  assign lt_unsigned = (alu_bus.src_a < alu_bus.src_b);
  assign lt_signed   = ($signed(alu_bus.src_a) < $signed(alu_bus.src_b));

  // Single-cycle datapath; in the iterative build a shift only lands here when shamt is 0.
  always_comb begin
    alu_result = '0;
    case (alu_bus.alu_control)
      OP_ADD:  alu_result = alu_bus.src_a + alu_bus.src_b;
      OP_SUB:  alu_result = alu_bus.src_a - alu_bus.src_b;
      OP_AND:  alu_result = alu_bus.src_a & alu_bus.src_b;
      OP_OR:   alu_result = alu_bus.src_a | alu_bus.src_b;
      OP_SLTU: alu_result = {{(DATA_WIDTH-1){1'b0}}, lt_unsigned};
      OP_SLT:  alu_result = {{(DATA_WIDTH-1){1'b0}}, lt_signed};
`ifdef MULTICYCLE_ALU_BARREL_SHIFT_EN
      OP_SLL:  alu_result = alu_bus.src_a << shamt;
      OP_SRL:  alu_result = alu_bus.src_a >> shamt;
`else
      OP_SLL:  alu_result = alu_bus.src_a;
      OP_SRL:  alu_result = alu_bus.src_a;
`endif
      default: alu_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
`ifndef MULTICYCLE_ALU_BARREL_SHIFT_EN
      acc_q    <= '0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
`ifndef MULTICYCLE_ALU_BARREL_SHIFT_EN
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
`ifndef MULTICYCLE_ALU_BARREL_SHIFT_EN
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    acc_step = left_q ? (acc_q << 1) : (acc_q >> 1);
`endif

    case (state_q)
      IDLE: begin
        if (alu_bus.in_valid) begin
`ifndef MULTICYCLE_ALU_BARREL_SHIFT_EN
          if (is_shift && (shamt != '0)) begin
            acc_d   = alu_bus.src_a;
            cnt_d   = shamt;
            left_d  = ~alu_bus.alu_control[0];
            state_d = SHIFT;
          end else begin
            result_d = alu_result;
            zero_d   = (alu_result == '0);
            state_d  = DONE;
          end
`else
          result_d = alu_result;
          zero_d   = (alu_result == '0);
          state_d  = DONE;
`endif
        end
      end

      SHIFT: begin
`ifndef MULTICYCLE_ALU_BARREL_SHIFT_EN
        acc_d = acc_step;
        cnt_d = cnt_q - 1'b1;
        // Last step: commit the accumulator as it will look after this edge.
        if (cnt_q == SHAMT_W'(1)) begin
          result_d = acc_step;
          zero_d   = (acc_step == '0);
          state_d  = DONE;
        end
`else
        state_d = IDLE;
`endif
      end

      DONE: begin
        if (alu_bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign alu_bus.in_ready  = (state_q == IDLE);
  assign alu_bus.out_valid = (state_q == DONE);
  assign alu_bus.result    = result_q;
  assign alu_bus.zero      = zero_q;

`ifdef MULTICYCLE_ALU_BARREL_SHIFT_EN
  logic unused_is_shift;
  assign unused_is_shift = is_shift;
`endif

endmodule
